// File: rtl/gpi_pkg.sv
// Shared definitions for the general-purpose input peripheral.
// Holds the byte offsets of each register, the register-index enum decoded
// from device_addr_i[4:2], and a byte-enable to bit-mask helper.
package gpi_pkg;

  localparam logic [4:0] GPI_VALUE   = 5'h00;
  localparam logic [4:0] GPI_RISE_EN = 5'h04;
  localparam logic [4:0] GPI_FALL_EN = 5'h08;
  localparam logic [4:0] GPI_STATUS  = 5'h0C;
  localparam logic [4:0] GPI_RAW     = 5'h10;

  typedef enum logic [2:0] {
    REG_VALUE   = 3'd0,
    REG_RISE_EN = 3'd1,
    REG_FALL_EN = 3'd2,
    REG_STATUS  = 3'd3,
    REG_RAW     = 3'd4,
    REG_RSVD5   = 3'd5,
    REG_RSVD6   = 3'd6,
    REG_RSVD7   = 3'd7
  } gpi_reg_e;

  // Expand the four byte enables into a 32-bit write mask.
  function automatic logic [31:0] be_to_mask(input logic [3:0] be);
    logic [31:0] mask;
    for (int b = 0; b < 4; b++) begin
      mask[b*8 +: 8] = {8{be[b]}};
    end
    return mask;
  endfunction

endpackage

// File: rtl/gpi_device_if.sv
// System bus responder interface for the general-purpose input peripheral.
// master: the system-side requester (drives req/addr/we/be/wdata).
// slave:  the peripheral (returns rvalid/rdata one cycle after each request).
interface gpi_device_if;
  logic        device_req_i;
  logic [31:0] device_addr_i;
  logic        device_we_i;
  logic [3:0]  device_be_i;
  logic [31:0] device_wdata_i;
  logic        device_rvalid_o;
  logic [31:0] device_rdata_o;

  modport master (
    output device_req_i, device_addr_i, device_we_i, device_be_i, device_wdata_i,
    input  device_rvalid_o, device_rdata_o
  );

  modport slave (
    input  device_req_i, device_addr_i, device_we_i, device_be_i, device_wdata_i,
    output device_rvalid_o, device_rdata_o
  );
endinterface

// File: rtl/gpi_debounce_bit.sv
// One input channel: two-flop synchroniser, debounce counter and debounced
// value register.
// Ports:
//   clk_i, rst_i : clock, synchronous active-high reset
//   gp_i         : asynchronous external input
//   sync_o       : synchronised, undebounced input
//   deb_o        : debounced input
//   rise_o/fall_o: single-cycle strobes, high in the cycle whose closing edge
//                  updates deb_o to 1 / 0
module gpi_debounce_bit #(
  parameter int DebounceCycles = 4
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic gp_i,
  output logic sync_o,
  output logic deb_o,
  output logic rise_o,
  output logic fall_o
);

  localparam int CntW = (DebounceCycles > 1) ? $clog2(DebounceCycles) : 1;
  localparam logic [CntW-1:0] CntMax = CntW'(DebounceCycles - 1);

  logic            sync_p0;
  logic            sync_p1;
  logic            deb;
  logic [CntW-1:0] cnt;
  logic            accept;

  // The synchronised input has differed for DebounceCycles cycles.
  assign accept = (sync_p1 != deb) && (cnt == CntMax);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync_p0 <= 1'b0;
      sync_p1 <= 1'b0;
      deb     <= 1'b0;
      cnt     <= '0;
    end else begin
      // Synchroniser stages
      sync_p0 <= gp_i;
      sync_p1 <= sync_p0;
      // Debounce stage
      if (sync_p1 == deb) begin
        cnt <= '0;
      end else if (accept) begin
        deb <= sync_p1;
        cnt <= '0;
      end else begin
        cnt <= cnt + CntW'(1);
      end
    end
  end

  assign sync_o = sync_p1;
  assign deb_o  = deb;
  assign rise_o = accept & sync_p1;
  assign fall_o = accept & ~sync_p1;

endmodule

// File: rtl/gpi_device.sv
// General-purpose input peripheral: synchronises and debounces GpiWidth
// external inputs, records enabled rising/falling edges in a W1C STATUS
// register and raises a level interrupt while any STATUS bit is pending.
// Ports:
//   clk_i, rst_i : clock, synchronous active-high reset
//   bus          : bus responder (gpi_device_if.slave), one access per cycle,
//                  response one cycle later, reads return 0 when idle
//   gp_i         : asynchronous external inputs
//   irq_o        : level interrupt, OR of STATUS
module gpi_device
  import gpi_pkg::*;
#(
  parameter int GpiWidth       = 16,
  parameter int DebounceCycles = 4
) (
  input  logic                clk_i,
  input  logic                rst_i,
  gpi_device_if.slave         bus,
  input  logic [GpiWidth-1:0] gp_i,
  output logic                irq_o
);

  logic [GpiWidth-1:0] raw;
  logic [GpiWidth-1:0] deb;
  logic [GpiWidth-1:0] rise;
  logic [GpiWidth-1:0] fall;
  logic [GpiWidth-1:0] rise_en;
  logic [GpiWidth-1:0] fall_en;
  logic [GpiWidth-1:0] status;

  for (genvar i = 0; i < GpiWidth; i++) begin : g_bit
    gpi_debounce_bit #(
      .DebounceCycles(DebounceCycles)
    ) u_bit (
      .clk_i (clk_i),
      .rst_i (rst_i),
      .gp_i  (gp_i[i]),
      .sync_o(raw[i]),
      .deb_o (deb[i]),
      .rise_o(rise[i]),
      .fall_o(fall[i])
    );
  end

  gpi_reg_e            reg_sel;
  logic                wr;
  logic [31:0]         be_mask;
  logic [GpiWidth-1:0] wmask;
  logic [GpiWidth-1:0] wdata;
  logic [GpiWidth-1:0] w1c;
  logic [GpiWidth-1:0] set;
  logic [31:0]         rd_mux;

  assign reg_sel = gpi_reg_e'(bus.device_addr_i[4:2]);
  assign wr      = bus.device_req_i & bus.device_we_i;
  assign be_mask = be_to_mask(bus.device_be_i);
  assign wmask   = be_mask[GpiWidth-1:0];
  assign wdata   = bus.device_wdata_i[GpiWidth-1:0];

  // Clear and set are evaluated together so a new edge beats a same-cycle W1C.
  assign w1c = (wr && reg_sel == REG_STATUS) ? (wdata & wmask) : '0;
  assign set = (rise & rise_en) | (fall & fall_en);

  always_comb begin
    rd_mux = '0;
    case (reg_sel)
      REG_VALUE:   rd_mux[GpiWidth-1:0] = deb;
      REG_RISE_EN: rd_mux[GpiWidth-1:0] = rise_en;
      REG_FALL_EN: rd_mux[GpiWidth-1:0] = fall_en;
      REG_STATUS:  rd_mux[GpiWidth-1:0] = status;
      REG_RAW:     rd_mux[GpiWidth-1:0] = raw;
      default:     rd_mux = '0;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rise_en             <= '0;
      fall_en             <= '0;
      status              <= '0;
      bus.device_rvalid_o <= 1'b0;
      bus.device_rdata_o  <= '0;
    end else begin
      if (wr && reg_sel == REG_RISE_EN) begin
        rise_en <= (rise_en & ~wmask) | (wdata & wmask);
      end
      if (wr && reg_sel == REG_FALL_EN) begin
        fall_en <= (fall_en & ~wmask) | (wdata & wmask);
      end
      status <= (status & ~w1c) | set;
      // Response stage
      bus.device_rvalid_o <= bus.device_req_i;
      bus.device_rdata_o  <= (bus.device_req_i && !bus.device_we_i) ? rd_mux : '0;
    end
  end

  assign irq_o = |status;

  // Address bits outside [4:2] and write data above GpiWidth are don't-care.
  logic unused_bus;
  assign unused_bus = ^{bus.device_addr_i[31:5], bus.device_addr_i[1:0],
                        bus.device_wdata_i, be_mask};

endmodule
